// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Brief    : EX-stage ALU with valid/ready handshake; iterative shifts.
// Revision : 1.0
// ============================================================================
module alu_exec_unit #(
    parameter int WIDTH      = 32,
    parameter int SHAMT_W    = 5,
    parameter int SHIFT_STEP = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         cu_to_alu,
    input  logic [5:0]         funct,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               overflow,
    output logic               illegal
);

    localparam logic [2:0] c_op_and = 3'b000;
    localparam logic [2:0] c_op_or  = 3'b001;
    localparam logic [2:0] c_op_add = 3'b010;
    localparam logic [2:0] c_op_sll = 3'b011;
    localparam logic [2:0] c_op_srl = 3'b100;
    localparam logic [2:0] c_op_sra = 3'b101;
    localparam logic [2:0] c_op_sub = 3'b110;
    localparam logic [2:0] c_op_slt = 3'b111;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    localparam logic [SHAMT_W-1:0] c_step = SHAMT_W'(SHIFT_STEP);

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_work;
    logic [SHAMT_W-1:0] r_remaining;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_overflow;
    logic               r_illegal;

    logic [2:0]         w_op;
    logic               w_illegal;
    logic               w_is_shift;
    logic               w_accept;
    logic               w_start_shift;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic               w_slt;
    logic [WIDTH-1:0]   w_alu_result;
    logic               w_alu_ovf;
    logic [SHAMT_W-1:0] w_n;
    logic [WIDTH-1:0]   w_shifted;
    logic               w_shift_last;

    // Operation decode: CU class first, funct only for R-type.
    always_comb begin
        w_op      = c_op_add;
        w_illegal = 1'b0;
        case (cu_to_alu)
            2'b00: w_op = c_op_add;
            2'b01: w_op = c_op_sub;
            2'b11: w_op = c_op_and;
            default: begin
                case (funct)
                    6'b100000: w_op = c_op_add;
                    6'b100010: w_op = c_op_sub;
                    6'b100100: w_op = c_op_and;
                    6'b100101: w_op = c_op_or;
                    6'b101010: w_op = c_op_slt;
                    6'b000000: w_op = c_op_sll;
                    6'b000010: w_op = c_op_srl;
                    6'b000011: w_op = c_op_sra;
                    default:   w_illegal = 1'b1;
                endcase
            end
        endcase
    end

    assign w_is_shift    = (w_op == c_op_sll) || (w_op == c_op_srl) || (w_op == c_op_sra);
    assign w_accept      = in_valid && (r_state == c_st_idle);
    assign w_start_shift = w_is_shift && (shamt != '0);

    assign w_sum  = op_a + op_b;
    assign w_diff = op_a - op_b;
    assign w_slt  = $signed(op_a) < $signed(op_b);

    // Single-cycle result; shifts only land here when shamt is zero.
    always_comb begin
        w_alu_result = '0;
        w_alu_ovf    = 1'b0;
        case (w_op)
            c_op_add: begin
                w_alu_result = w_sum;
                w_alu_ovf    = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (w_sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            c_op_sub: begin
                w_alu_result = w_diff;
                w_alu_ovf    = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (w_diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            c_op_and: w_alu_result = op_a & op_b;
            c_op_or:  w_alu_result = op_a | op_b;
            c_op_slt: w_alu_result = {{(WIDTH-1){1'b0}}, w_slt};
            default:  w_alu_result = op_b;
        endcase
        if (w_illegal) begin
            w_alu_result = '0;
            w_alu_ovf    = 1'b0;
        end
    end

    assign w_n          = (r_remaining < c_step) ? r_remaining : c_step;
    assign w_shift_last = (r_remaining == w_n);

    always_comb begin
        case (r_op)
            c_op_sll: w_shifted = r_work << w_n;
            c_op_srl: w_shifted = r_work >> w_n;
            default:  w_shifted = $unsigned($signed(r_work) >>> w_n);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (in_valid) begin
                    w_state_next = w_start_shift ? c_st_shift : c_st_done;
                end
            end
            c_st_shift: begin
                if (w_shift_last) begin
                    w_state_next = c_st_done;
                end
            end
            c_st_done: begin
                if (out_ready) begin
                    w_state_next = c_st_idle;
                end
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_st_idle);
        out_valid = (r_state == c_st_done);
    end

    // Result registers only move at accept or on the final shift step,
    // which keeps them stable while a result is stalled in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= c_op_and;
            r_work      <= '0;
            r_remaining <= '0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_accept) begin
            r_op <= w_op;
            if (w_start_shift) begin
                r_work      <= op_b;
                r_remaining <= shamt;
            end else begin
                r_result   <= w_alu_result;
                r_zero     <= (w_alu_result == '0);
                r_overflow <= w_alu_ovf;
                r_illegal  <= w_illegal;
            end
        end else if (r_state == c_st_shift) begin
            r_work      <= w_shifted;
            r_remaining <= r_remaining - w_n;
            if (w_shift_last) begin
                r_result   <= w_shifted;
                r_zero     <= (w_shifted == '0);
                r_overflow <= 1'b0;
                r_illegal  <= 1'b0;
            end
        end
    end

    assign result   = r_result;
    assign zero     = r_zero;
    assign overflow = r_overflow;
    assign illegal  = r_illegal;

endmodule
`default_nettype wire
